// File: rtl/prbs9_checker.sv
// prbs9_checker: self-synchronising PRBS9 (x^9+x^5+1) checker with lock FSM and BER counters
module prbs9_checker #(
   parameter int NB_INPUT = 8,
   parameter int NB_CNT   = 32,
   parameter int LOCK_CNT = 16,
   parameter int WIN_LEN  = 128,
   parameter int ERR_THR  = 32
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_enable,
   input  logic                       i_valid,
   input  logic signed [NB_INPUT-1:0] i_symb,
   output logic                       o_lock,
   output logic                       o_err,
   output logic [NB_CNT-1:0]          o_bit_count,
   output logic [NB_CNT-1:0]          o_err_count
);
   localparam logic [0:0] SEARCH = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WIN_LEN + 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
   localparam logic [WW-1:0] THR       = WW'(ERR_THR);

   logic [0:0]    state;
   logic [8:0]    hist;
   logic [3:0]    fill;
   logic [MW-1:0] match_cnt;
   logic [WW-1:0] win_cnt;
   logic [WW-1:0] win_err;
   logic          acc;
   logic          b;
   logic          e;
   logic          mis;
   logic [WW-1:0] win_err_n;
   logic          unused_symb;

   assign unused_symb = ^i_symb[NB_INPUT-2:0];
   assign o_lock = state == LOCKED;

   // slice the symbol, predict the next bit and pre-compute the window error total
   always_comb begin
      acc       = i_enable & i_valid;
      b         = i_symb[NB_INPUT-1];
      e         = hist[8] ^ hist[4];
      mis       = b ^ e;
      win_err_n = win_err + (mis ? WW'(1) : WW'(0));
   end

   // lock FSM, reference history, window supervision and saturating BER counters
   always_ff @(posedge clk) begin
      if (!i_rst) begin
         state       <= SEARCH;
         hist        <= '0;
         fill        <= '0;
         match_cnt   <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         o_err       <= 1'b0;
         o_bit_count <= '0;
         o_err_count <= '0;
      end else begin
         o_err <= acc && state == LOCKED && mis;
         if (acc && state == SEARCH) begin
            hist <= {hist[7:0], b};
            if (fill != 4'd9)
               fill <= fill + 4'd1;
            else if (!mis && |hist) begin
               match_cnt <= match_cnt + MW'(1);
               if (match_cnt == LOCK_LAST) begin
                  state   <= LOCKED;
                  win_cnt <= '0;
                  win_err <= '0;
               end
            end else
               match_cnt <= '0;
         end else if (acc) begin
            hist <= {hist[7:0], e};
            if (o_bit_count != '1) o_bit_count <= o_bit_count + NB_CNT'(1);
            if (mis && o_err_count != '1) o_err_count <= o_err_count + NB_CNT'(1);
            if (win_cnt == WIN_LAST) begin
               win_cnt <= '0;
               win_err <= '0;
               if (win_err_n > THR) begin
                  state     <= SEARCH;
                  fill      <= '0;
                  match_cnt <= '0;
               end
            end else begin
               win_cnt <= win_cnt + WW'(1);
               win_err <= win_err_n;
            end
         end
      end
   end
endmodule
